// File: rtl/dlx_alu_pkg.sv
// Shared DLX ALU result types: op codes, branch codes and the
// buffered EX result entry consumed by the MEM stage.
package dlx_alu_pkg;

  localparam int ALU_DW = 32;
  localparam int ALU_RW = 5;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLL  = 4'b0101;
  localparam logic [3:0] OP_SRL  = 4'b0110;
  localparam logic [3:0] OP_SLTU = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1000;
  localparam logic [3:0] OP_SGEQ = 4'b1001;

  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_EQZ  = 2'b01;
  localparam logic [1:0] BR_NEZ  = 2'b10;

  typedef struct packed {
    logic [ALU_DW-1:0] result;
    logic [ALU_RW-1:0] rd;
    logic              wr_en;
    logic              br_taken;
    logic [3:0]        flags;
  } ex_entry_t;

  function automatic logic is_set_op(
    input logic [3:0] op
  );
    return (op == OP_SLTU) ||
           (op == OP_SLT)  ||
           (op == OP_SGEQ);
  endfunction

  function automatic logic is_arith_op(
    input logic [3:0] op
  );
    return (op == OP_ADD) ||
           (op == OP_SUB);
  endfunction

endpackage

// File: rtl/ex_result_fixup.sv
// Combinational map from raw ALU outputs to a buffered entry:
// set-op result fix-up, branch resolution, write enable and trap.
module ex_result_fixup
  import dlx_alu_pkg::*;
(
  input  logic [ALU_DW-1:0] result_i,
  input  logic              carry_i,
  input  logic              ovf_i,
  input  logic              zero_i,
  input  logic              set_i,
  input  logic [3:0]        op_i,
  input  logic [ALU_RW-1:0] rd_i,
  input  logic              trap_en_i,
  input  logic [1:0]        br_i,
  output ex_entry_t         entry_o,
  output logic              trap_hit_o
);

  logic is_br;
  logic taken;

  // Resolve branch; reserved code 11 behaves as no branch
  always_comb begin
    is_br = 1'b0;
    taken = 1'b0;
    unique case (1'b1)
      (br_i == BR_EQZ): begin
        is_br = 1'b1;
        taken = zero_i;
      end
      (br_i == BR_NEZ): begin
        is_br = 1'b1;
        taken = ~zero_i;
      end
      default: ;
    endcase
  end

  // Build the entry; trapping entries keep data but never write
  always_comb begin
    trap_hit_o = trap_en_i & ovf_i & is_arith_op(op_i);
    entry_o.result = is_set_op(op_i) ?
      {{(ALU_DW-1){1'b0}}, set_i} : result_i;
    entry_o.rd = rd_i;
    entry_o.wr_en = (rd_i != '0) & ~is_br & ~trap_hit_o;
    entry_o.br_taken = taken;
    entry_o.flags = {carry_i, ovf_i, zero_i, set_i};
  end

endmodule

// File: rtl/ex_result_stage.sv
// EX result stage: captures ALU results into a 2-entry skid
// buffer toward MEM, raises overflow traps, drives the fwd tap.
module ex_result_stage
  import dlx_alu_pkg::*;
#(
  parameter int DW  = ALU_DW,
  parameter int RW  = ALU_RW,
  parameter int TCW = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [DW-1:0]  in_result,
  input  logic           in_carry,
  input  logic           in_ovf,
  input  logic           in_zero,
  input  logic           in_set,
  input  logic [3:0]     in_op,
  input  logic [RW-1:0]  in_rd,
  input  logic           in_trap_en,
  input  logic [1:0]     in_br,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [DW-1:0]  out_result,
  output logic [RW-1:0]  out_rd,
  output logic           out_wr_en,
  output logic           out_br_taken,
  output logic [3:0]     out_flags,
  output logic           trap,
  input  logic           trap_ack,
  output logic [TCW-1:0] trap_count,
  output logic           fwd_valid,
  output logic [RW-1:0]  fwd_rd,
  output logic [DW-1:0]  fwd_data
);

  ex_entry_t fix_e;
  logic      fix_trap;

  ex_entry_t head_q, head_d;
  ex_entry_t skid_q, skid_d;
  logic      head_v_q, head_v_d;
  logic      skid_v_q, skid_v_d;

  logic           trap_q, trap_d;
  logic [TCW-1:0] tcnt_q, tcnt_d;

  logic accept;
  logic pop;
  logic hit;

  ex_result_fixup u_fixup (
    .result_i   (in_result),
    .carry_i    (in_carry),
    .ovf_i      (in_ovf),
    .zero_i     (in_zero),
    .set_i      (in_set),
    .op_i       (in_op),
    .rd_i       (in_rd),
    .trap_en_i  (in_trap_en),
    .br_i       (in_br),
    .entry_o    (fix_e),
    .trap_hit_o (fix_trap)
  );

  assign in_ready = ~skid_v_q & ~trap_q;
  assign accept   = in_valid & in_ready;
  assign pop      = head_v_q & out_ready;
  assign hit      = accept & fix_trap;

  // Skid buffer next state; skid full blocks accept, so a
  // pop with skid full only shifts skid into head
  always_comb begin
    head_d   = head_q;
    skid_d   = skid_q;
    head_v_d = head_v_q;
    skid_v_d = skid_v_q;
    if (pop) begin
      if (skid_v_q) begin
        head_d   = skid_q;
        skid_v_d = 1'b0;
      end else if (accept) begin
        head_d = fix_e;
      end else begin
        head_v_d = 1'b0;
      end
    end else if (accept) begin
      if (!head_v_q) begin
        head_d   = fix_e;
        head_v_d = 1'b1;
      end else begin
        skid_d   = fix_e;
        skid_v_d = 1'b1;
      end
    end
  end

  // Sticky trap with set priority over ack; saturating counter
  always_comb begin
    trap_d = trap_q;
    tcnt_d = tcnt_q;
    if (hit) begin
      trap_d = 1'b1;
      if (tcnt_q != '1) begin
        tcnt_d = tcnt_q + 1'b1;
      end
    end else if (trap_ack) begin
      trap_d = 1'b0;
    end
  end

  // State registers; reset drops every buffered entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q   <= '0;
      skid_q   <= '0;
      head_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      trap_q   <= 1'b0;
      tcnt_q   <= '0;
    end else begin
      head_q   <= head_d;
      skid_q   <= skid_d;
      head_v_q <= head_v_d;
      skid_v_q <= skid_v_d;
      trap_q   <= trap_d;
      tcnt_q   <= tcnt_d;
    end
  end

  assign out_valid    = head_v_q;
  assign out_result   = head_q.result;
  assign out_rd       = head_q.rd;
  assign out_wr_en    = head_v_q & head_q.wr_en;
  assign out_br_taken = head_v_q & head_q.br_taken;
  assign out_flags    = head_q.flags;
  assign trap         = trap_q;
  assign trap_count   = tcnt_q;

  // Forward the youngest buffered entry that writes a register
  always_comb begin
    fwd_valid = 1'b0;
    fwd_rd    = '0;
    fwd_data  = '0;
    unique case (1'b1)
      (skid_v_q & skid_q.wr_en): begin
        fwd_valid = 1'b1;
        fwd_rd    = skid_q.rd;
        fwd_data  = skid_q.result;
      end
      (~(skid_v_q & skid_q.wr_en) &
       head_v_q & head_q.wr_en): begin
        fwd_valid = 1'b1;
        fwd_rd    = head_q.rd;
        fwd_data  = head_q.result;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ex_result_stage.sv
// Scoreboard bench for ex_result_stage: directed cases plus a
// randomized run checked against a behavioural model.
module tb_ex_result_stage;

  localparam int DW = 32;
  localparam int RW = 5;
  localparam int TCW = 8;

  typedef struct {
    logic [DW-1:0] result;
    logic [RW-1:0] rd;
    logic          wr;
    logic          taken;
    logic [3:0]    flags;
  } exp_t;

  logic           clk = 0;
  logic           rst_n = 0;
  logic           in_valid = 0;
  logic           in_ready;
  logic [DW-1:0]  in_result = 0;
  logic           in_carry = 0;
  logic           in_ovf = 0;
  logic           in_zero = 0;
  logic           in_set = 0;
  logic [3:0]     in_op = 0;
  logic [RW-1:0]  in_rd = 0;
  logic           in_trap_en = 0;
  logic [1:0]     in_br = 0;
  logic           out_valid;
  logic           out_ready = 1;
  logic [DW-1:0]  out_result;
  logic [RW-1:0]  out_rd;
  logic           out_wr_en;
  logic           out_br_taken;
  logic [3:0]     out_flags;
  logic           trap;
  logic           trap_ack = 0;
  logic [TCW-1:0] trap_count;
  logic           fwd_valid;
  logic [RW-1:0]  fwd_rd;
  logic [DW-1:0]  fwd_data;

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];
  int exp_tc = 0;
  bit rdone = 0;

  ex_result_stage #(.DW(DW), .RW(RW), .TCW(TCW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_carry(in_carry),
    .in_ovf(in_ovf), .in_zero(in_zero), .in_set(in_set),
    .in_op(in_op), .in_rd(in_rd), .in_trap_en(in_trap_en),
    .in_br(in_br), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result),
    .out_rd(out_rd), .out_wr_en(out_wr_en),
    .out_br_taken(out_br_taken), .out_flags(out_flags),
    .trap(trap), .trap_ack(trap_ack),
    .trap_count(trap_count), .fwd_valid(fwd_valid),
    .fwd_rd(fwd_rd), .fwd_data(fwd_data)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name,
                              logic [63:0] act,
                              logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h",
               name, act, req);
    end
  endfunction

  function automatic bit traps(logic [3:0] op,
                               logic ovf, logic te);
    return te && ovf && (op == 4'd2 || op == 4'd3);
  endfunction

  function automatic exp_t model(
    logic [3:0] op, logic [DW-1:0] res, logic c,
    logic o, logic z, logic s, logic [RW-1:0] rd,
    logic te, logic [1:0] br);
    exp_t m;
    bit is_br;
    is_br = (br == 2'd1) || (br == 2'd2);
    if (op == 4'd7 || op == 4'd8 || op == 4'd9)
      m.result = DW'(s);
    else
      m.result = res;
    m.rd = rd;
    m.taken = (br == 2'd1) ? z : (br == 2'd2) ? !z : 1'b0;
    m.wr = (rd != 0) && !is_br && !traps(op, o, te);
    m.flags = {c, o, z, s};
    return m;
  endfunction

  // Scoreboard push on every accepted transfer
  always @(posedge clk) begin
    if (rst_n && in_valid && in_ready) begin
      exp_q.push_back(model(in_op, in_result, in_carry,
        in_ovf, in_zero, in_set, in_rd, in_trap_en, in_br));
      if (traps(in_op, in_ovf, in_trap_en) &&
          exp_tc < (1 << TCW) - 1)
        exp_tc++;
    end
  end

  // Monitor: each head seen with ready is popped next edge
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("out_result", out_result, e.result);
        chk("out_rd", out_rd, e.rd);
        chk("out_wr_en", out_wr_en, e.wr);
        chk("out_br_taken", out_br_taken, e.taken);
        chk("out_flags", out_flags, e.flags);
      end
    end
  end

  task automatic idle(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(logic [3:0] op, logic [DW-1:0] res,
                      logic c, logic o, logic z, logic s,
                      logic [RW-1:0] rd, logic te,
                      logic [1:0] br);
    bit acc;
    int n;
    in_op = op; in_result = res; in_carry = c;
    in_ovf = o; in_zero = z; in_set = s;
    in_rd = rd; in_trap_en = te; in_br = br;
    in_valid = 1;
    n = 0;
    do begin
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 100);
    if (!acc) chk("accept_timeout", 0, 1);
    in_valid = 0;
  endtask

  initial begin
    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_trap", trap, 0);
    chk("rst_trap_count", trap_count, 0);
    chk("rst_fwd_valid", fwd_valid, 0);
    chk("rst_out_result", out_result, 0);
    #20 rst_n = 1;
    @(posedge clk); #1;
    chk("rst_in_ready", in_ready, 1);

    send(4'b1000, 0, 0, 0, 0, 1, 3, 0, 0);
    chk("slt_valid", out_valid, 1);
    chk("slt_result", out_result, 1);
    chk("slt_wr_en", out_wr_en, 1);
    chk("slt_fwd_rd", fwd_rd, 3);

    send(4'b0010, 32'h80000061, 0, 1, 0, 0, 4, 1, 0);
    chk("trap_wr_en", out_wr_en, 0);
    chk("trap_set", trap, 1);
    chk("trap_count1", trap_count, 1);
    chk("trap_in_ready", in_ready, 0);
    trap_ack = 1;
    idle(1);
    trap_ack = 0;
    chk("trap_clear", trap, 0);
    chk("trap_ack_ready", in_ready, 1);
    chk("trap_count_held", trap_count, 1);

    send(4'b0010, 0, 1, 0, 1, 0, 7, 0, 2'b01);
    chk("beqz_taken", out_br_taken, 1);
    chk("beqz_wr_en", out_wr_en, 0);
    send(4'b0010, 0, 1, 0, 1, 0, 7, 0, 2'b10);
    chk("bnez_taken", out_br_taken, 0);
    idle(1);

    out_ready = 0;
    send(4'b0100, 32'hA, 0, 0, 0, 0, 1, 0, 0);
    send(4'b0000, 32'h5, 0, 0, 0, 0, 2, 0, 0);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_head", out_result, 32'hA);
    chk("bp_fwd_rd", fwd_rd, 2);
    chk("bp_fwd_data", fwd_data, 32'h5);
    out_ready = 1;
    idle(3);
    chk("bp_drained", exp_q.size(), 0);

    send(4'b0100, 32'h1234, 0, 0, 0, 0, 0, 0, 0);
    chk("rd0_wr_en", out_wr_en, 0);
    chk("rd0_fwd_valid", fwd_valid, 0);
    idle(1);

    out_ready = 0;
    send(4'b0001, 32'h11, 0, 0, 0, 0, 5, 0, 0);
    send(4'b0001, 32'h22, 0, 0, 0, 0, 6, 0, 0);
    #2 rst_n = 0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_trap_count", trap_count, 0);
    chk("arst_fwd_valid", fwd_valid, 0);
    exp_q.delete();
    exp_tc = 0;
    #3 rst_n = 1;
    idle(1);
    out_ready = 1;

    fork
      begin
        for (int i = 0; i < 400; i++) begin
          logic [1:0] br;
          br = ($urandom % 4 == 0) ? 2'($urandom) : 2'd0;
          send(4'($urandom), $urandom, 1'($urandom),
               1'($urandom), 1'($urandom), 1'($urandom),
               5'($urandom), ($urandom % 6 == 0), br);
          if ($urandom % 3 == 0) idle(1);
        end
        rdone = 1;
      end
      begin
        while (!rdone) begin
          @(posedge clk); #1;
          out_ready = ($urandom % 4) != 0;
          trap_ack = trap && ($urandom % 2 == 1);
        end
      end
    join
    out_ready = 1;
    trap_ack = 1;
    idle(1);
    trap_ack = 0;
    chk("rand_trap_count", trap_count, exp_tc);

    for (int i = 0; i < (1 << TCW) + 2; i++) begin
      send(4'b0011, $urandom, 0, 1, 0, 0,
           5'($urandom), 1, 0);
      trap_ack = 1;
      idle(1);
      trap_ack = 0;
    end
    chk("sat_trap_count", trap_count, (1 << TCW) - 1);
    chk("sat_model_count", trap_count, exp_tc);

    for (int i = 0; i < 50 && exp_q.size() != 0; i++)
      idle(1);
    chk("final_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_result_stage.md
Name: ex_result_stage

Overview:
- Consumer end of the ALU interface in the final DLX pipeline: sits between the combinational alu (EX) and the MEM stage.
- Captures Result/Carryout/Overflow/Zero/Set with the issuing Op and destination register, then resolves branches and set-ops.
- Raises overflow traps and buffers up to two results behind a valid/ready skid buffer so MEM back-pressure never drops an ALU result.
- Drives an EX-to-ID forwarding tap.

Parameters:
- DW, 32, data width of ALU result.
- RW, 5, register index width.
- TCW, 16, trap counter width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  EX holds a valid ALU result.
- in_ready  out  1  stage can accept this cycle.
- in_result  in  DW  alu Result.
- in_carry  in  1  alu Carryout.
- in_ovf  in  1  alu Overflow.
- in_zero  in  1  alu Zero.
- in_set  in  1  alu Set.
- in_op  in  4  alu Op code.
- in_rd  in  RW  destination register.
- in_trap_en  in  1  signed op: overflow traps.
- in_br  in  2  00 none, 01 BEQZ, 10 BNEZ, 11 reserved (treated as none).
- out_valid  out  1  head entry valid.
- out_ready  in  1  MEM accepts head.
- out_result  out  DW  final result.
- out_rd  out  RW  destination.
- out_wr_en  out  1  register write enable.
- out_br_taken  out  1  branch resolved taken.
- out_flags  out  4  {carry, ovf, zero, set} of head.
- trap  out  1  sticky overflow trap pending.
- trap_ack  in  1  clears trap.
- trap_count  out  TCW  saturating trap count.
- fwd_valid  out  1  forwarding tap valid.
- fwd_rd  out  RW  forwarding register.
- fwd_data  out  DW  forwarding data.

Behaviour:
- Op encoding:
  - 0000 and, 0001 or, 0010 add, 0011 sub, 0100 xor.
  - 0101 sll, 0110 srl, 0111 sltu, 1000 slt, 1001 sgeq.
  - 1010-1111 pass Result unchanged.
- Result fix-up, applied at capture:
  - Ops 0111/1000/1001: out_result = {DW-1 zeros, in_set}.
  - All other ops: out_result = in_result.
- Branch resolution at capture:
  - BEQZ taken = in_zero.
  - BNEZ taken = !in_zero.
  - Branch entries have wr_en=0.
- Trap condition: in_trap_en & in_ovf & op in {0010, 0011}.
  - Trapping entry is stored with wr_en=0, keeping its result and flags.
  - trap is set the cycle after capture.
  - trap_count increments and saturates at all-ones.
- wr_en = 0 when rd == 0; otherwise 1 unless the entry is a branch or a trap.
- Skid buffer: 2 entries, head and skid, with in-order output.
  - in_ready = !skid_full & !trap.
  - Accept when in_valid & in_ready; head is presented directly when empty.
  - Capture-to-out_valid latency is 1 cycle.
- Simultaneous accept and pop: throughput is 1 per cycle.
  - Skid never fills while out_ready stays high.
- out_ready low with head full: the next accept goes to skid and in_ready drops.
- Pop with skid full: skid moves to head in the same cycle.
- While trap=1:
  - in_ready=0.
  - Already-buffered entries still drain.
- trap_ack:
  - Clears trap on the next edge; trap_count is held.
  - trap_ack on the same cycle as a new trap capture: set wins.
- Forwarding tap reflects the youngest valid buffered entry with wr_en=1: skid if valid, else head.
  - fwd_valid=0 when no such entry exists.
- All outputs are registered, or decoded purely from registers.
- Reset values:
  - out_valid, out_wr_en, out_br_taken, trap, fwd_valid = 0.
  - out_result, out_rd, out_flags, fwd_rd, fwd_data = 0.
  - trap_count = 0.
  - in_ready is 1 once reset is released.
- Reset mid-operation discards all buffered entries immediately (async).

Decomposition:
- Shared package dlx_alu_pkg holds:
  - 4-bit Op constants (OP_AND..OP_SGEQ).
  - Branch codes BR_NONE/BR_EQZ/BR_NEZ.
  - A packed entry typedef {result, rd, wr_en, br_taken, flags}.
- One sub-module, ex_result_fixup: purely combinational. Maps the ALU outputs, op, rd, br and trap_en to the entry struct plus a trap_hit signal.
- The skid buffer, trap logic and counter live in the top level.

Test Plan:
- Input in_op=1000, in_result=0x0, in_set=1, in_rd=3, out_ready=1.
  - Expect next cycle: out_valid=1, out_result=0x00000001, out_wr_en=1, fwd_rd=3.
- Input in_op=0010, in_result=0x80000061, in_ovf=1, in_trap_en=1, in_rd=4.
  - Expect out_wr_en=0, trap=1, trap_count=1, in_ready=0.
  - Then pulse trap_ack: trap=0 and in_ready=1 on the next cycle.
- Branch with in_br=01, in_zero=1 (Result 0 from -1+1) -> out_br_taken=1, out_wr_en=0.
  - Same with in_br=10 -> out_br_taken=0.
- Back-pressure: hold out_ready=0 and push xor 0x0000000A then and 0x00000005.
  - Expect in_ready=0 after 2 accepts.
  - Release out_ready: outputs come out in order 0xA then 0x5, with no loss or duplicate.
- Input in_op=0100 with in_rd=0 -> out_wr_en=0 and fwd_valid=0.
  - Assert rst_n=0 with both entries full -> out_valid=0 and trap_count=0 immediately, without waiting for a clock.
- Force 2^TCW+2 trapping adds, each acked -> trap_count stays at 0xFFFF.
